iterative_divider: RTL

//   Multi-cycle 32-bit restoring divider for the MIPS datapath (DIV/DIVU).

---
 rtl/iterative_divider.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/iterative_divider.sv
// iterative_divider: multi-cycle restoring divider for MIPS DIV/DIVU.
// Computes one quotient bit per clock. The quotient is LO and the remainder is HI.
// Optional feature macro: SIGNED_DIV_EN (signed DIV support). When it is
// undefined, every division is unsigned and is_signed is ignored.
//
// Handshake: start is sampled on a rising edge only while busy==0, that is in
// IDLE or DONE. Sampling start in DONE allows back-to-back divisions. An
// accepted start captures dividend, divisor and is_signed. busy stays high for
// the WIDTH iteration cycles. done is high for exactly one cycle; during that
// cycle quotient, remainder and div_by_zero are valid. The results then hold
// until the next division completes.
module iterative_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] p;        // partial remainder, always < divisor
  logic [WIDTH-1:0] q;        // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] d;        // captured divisor magnitude
  logic             accept;
  logic             last;
  logic             zero_div;
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_trial;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  assign accept   = start && (state != CALC);
  assign last     = (cnt == CNT_W'(WIDTH - 1));
  assign zero_div = (divisor == '0);
  assign busy     = (state == CALC);
  assign done     = (state == DONE);

  // One restoring step: shift {P,Q} left, then trial-subtract the divisor.
  always_comb begin
    p_shift = {p, q[WIDTH-1]};
    p_trial = p_shift - {1'b0, d};
    if (!p_trial[WIDTH]) begin
      p_next = p_trial[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      p_next = p_shift[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

`ifdef SIGNED_DIV_EN
  logic neg_q;
  logic neg_r;

  // Signed DIV divides magnitudes. The final quotient and remainder are negated afterwards.
  always_comb begin
    a_mag = (is_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    b_mag = (is_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
    q_fin = neg_q ? (~q_next + 1'b1) : q_next;
    r_fin = neg_r ? (~p_next + 1'b1) : p_next;
  end

  // Remember the sign fix-ups at capture; the remainder follows the dividend sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r <= is_signed && dividend[WIDTH-1];
    end
  end
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;

  // Unsigned-only build: operands and results pass straight through.
  always_comb begin
    a_mag = dividend;
    b_mag = divisor;
    q_fin = q_next;
    r_fin = p_next;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic. A zero divisor skips the iterations entirely.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = zero_div ? DONE : CALC;
        end else begin
          state_n = IDLE;
        end
      end
      CALC: begin
        if (last) begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate in CALC, and load the results on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      p           <= '0;
      q           <= '0;
      d           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      p   <= '0;
      q   <= a_mag;
      d   <= b_mag;
      if (zero_div) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      p   <= p_next;
      q   <= q_next;
      if (last) begin
        quotient    <= q_fin;
        remainder   <= r_fin;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
